// File: rtl/host_exit_pkg.sv
// Shared types and constants for the host-exit controller: FSM states,
// MMIO request/response bundles and the finish-bus encoding.
package host_exit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_FIRE   = 2'd2,
    ST_HALTED = 2'd3
  } exit_state_t;

  localparam logic [7:0] EXIT_TIMEOUT_CODE = 8'hFF;
  localparam int         FINISH_ARG_W      = 9;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
  } mmio_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } mmio_rsp_t;

  function automatic logic [FINISH_ARG_W-1:0] finish_word(input logic [7:0] code);
    return {1'b1, code};
  endfunction

endpackage

// File: rtl/host_exit_counter.sv
// Loadable down-counter that holds at zero; load has priority over decrement.
module host_exit_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/host_exit_ctrl.sv
// MMIO host-exit controller: decodes tohost stores, drains, then emits a
// single-cycle {finish, exitcode} pulse; optional watchdog forces code 8'hFF.
//
//   state     | meaning
//   ST_IDLE   | waiting for an exit store or watchdog expiry
//   ST_DRAIN  | counting down the drain delay with the exit code latched
//   ST_FIRE   | finish_arg carries {1, code} for this one cycle
//   ST_HALTED | pulse issued; MMIO still served until reset
module host_exit_ctrl
  import host_exit_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = 32'h4000_1000,
  parameter int unsigned DRAIN_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_data,
  output logic [FINISH_ARG_W-1:0] finish_arg,
  output logic                    halted
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] WD_LOAD    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               WD_EN      = (TIMEOUT_CYCLES != 0);
  localparam bit               DRAIN_NONE = (DRAIN_CYCLES == 0);

  mmio_req_t               req;
  mmio_rsp_t               rsp_q, rsp_d;
  exit_state_t             state_q, state_d;
  logic [31:0]             tohost_q, tohost_d;
  logic [7:0]              code_q, code_d;
  logic [FINISH_ARG_W-1:0] finish_arg_q, finish_arg_d;
  logic                    halted_q, halted_d;
  logic                    wd_armed_q, wd_armed_d;

  logic                    accept, hit, exit_store, wd_expire;
  logic                    drain_load, drain_last, drain_zero, wd_zero;
  logic [CNT_W-1:0]        drain_cnt, unused_wd_cnt;

  assign req = '{valid: req_valid, wen: req_wen, addr: req_addr, data: req_data};

  assign req_ready  = !rsp_q.valid || rsp_ready;
  assign accept     = req.valid && req_ready;
  assign hit        = (req.addr == TOHOST_ADDR);
  assign exit_store = accept && req.wen && hit && req.data[0];

  always_comb begin
    rsp_d = rsp_q;
    if (accept) begin
      rsp_d.valid = 1'b1;
      rsp_d.data  = (!req.wen && hit) ? tohost_q : '0;
    end else if (rsp_ready) begin
      rsp_d.valid = 1'b0;
    end
  end

  assign tohost_d = (accept && req.wen && hit) ? req.data : tohost_q;

  // Watchdog loads TIMEOUT-1 in the first cycle after reset so that it hits
  // zero exactly TIMEOUT cycles after release; it freezes once we leave IDLE.
  assign wd_armed_d = 1'b1;
  assign wd_expire  = WD_EN && wd_armed_q && wd_zero;
  assign drain_last = (drain_cnt == CNT_W'(1)) || drain_zero;

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    drain_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exit_store || wd_expire) begin
          code_d     = exit_store ? req.data[8:1] : EXIT_TIMEOUT_CODE;
          drain_load = 1'b1;
          state_d    = DRAIN_NONE ? ST_FIRE : ST_DRAIN;
        end
      end
      ST_DRAIN: if (drain_last) state_d = ST_FIRE;
      ST_FIRE:  state_d = ST_HALTED;
      default:  state_d = ST_HALTED;
    endcase
  end

  assign finish_arg_d = (state_d == ST_FIRE) ? finish_word(code_d) : '0;
  assign halted_d     = (state_d == ST_HALTED);

  host_exit_counter #(.CNT_W(CNT_W)) u_drain_cnt (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (drain_load),
    .load_val (DRAIN_LOAD),
    .dec      (state_q == ST_DRAIN),
    .count    (drain_cnt),
    .zero     (drain_zero)
  );

  host_exit_counter #(.CNT_W(CNT_W)) u_wd_cnt (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (WD_EN && !wd_armed_q),
    .load_val (WD_LOAD),
    .dec      (WD_EN && wd_armed_q && (state_q == ST_IDLE)),
    .count    (unused_wd_cnt),
    .zero     (wd_zero)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      rsp_q        <= '0;
      tohost_q     <= '0;
      code_q       <= '0;
      finish_arg_q <= '0;
      halted_q     <= 1'b0;
      wd_armed_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsp_q        <= rsp_d;
      tohost_q     <= tohost_d;
      code_q       <= code_d;
      finish_arg_q <= finish_arg_d;
      halted_q     <= halted_d;
      wd_armed_q   <= wd_armed_d;
    end
  end

  assign rsp_valid  = rsp_q.valid;
  assign rsp_data   = rsp_q.data;
  assign finish_arg = finish_arg_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_host_exit_ctrl.sv
// Scoreboard bench for host_exit_ctrl: a drain-only instance under directed and
// random MMIO traffic, plus a watchdog-enabled instance with fixed timing runs.
module tb_host_exit_ctrl;

  localparam logic [31:0] TOHOST = 32'h4000_1000;
  localparam int          DRAIN  = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        a_rst_n, a_req_valid, a_req_ready, a_req_wen, a_rsp_valid, a_rsp_ready, a_halted;
  logic [31:0] a_req_addr, a_req_data, a_rsp_data;
  logic [8:0]  a_finish_arg;
  logic        b_rst_n, b_req_valid, b_req_ready, b_req_wen, b_rsp_valid, b_rsp_ready, b_halted;
  logic [31:0] b_req_addr, b_req_data, b_rsp_data;
  logic [8:0]  b_finish_arg;

  host_exit_ctrl #(.TOHOST_ADDR(TOHOST), .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(0), .CNT_W(32)) dut_a (
    .CLK(CLK), .RST_N(a_rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_wen(a_req_wen), .req_addr(a_req_addr), .req_data(a_req_data),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
    .finish_arg(a_finish_arg), .halted(a_halted));

  host_exit_ctrl #(.TOHOST_ADDR(TOHOST), .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(100), .CNT_W(32)) dut_b (
    .CLK(CLK), .RST_N(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_wen(b_req_wen), .req_addr(b_req_addr), .req_data(b_req_data),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .finish_arg(b_finish_arg), .halted(b_halted));

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_tohost;
  bit          m_exited;
  int          m_fire_cyc;
  logic [7:0]  m_code;
  bit          rr_force = 1'b0;
  bit          rr_rand  = 1'b0;
  bit          prev_valid = 1'b0;
  logic [31:0] held_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: one response per accepted request, tohost overwritten
  // by every tohost store, first odd store decides the exit code and fire cycle.
  function automatic void model_accept(input logic wen, input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back((!wen && addr == TOHOST) ? m_tohost : 32'h0);
    if (wen && addr == TOHOST) begin
      m_tohost = data;
      if (data[0] && !m_exited) begin
        m_exited   = 1'b1;
        m_code     = data[8:1];
        m_fire_cyc = cyc + 1 + DRAIN;
      end
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_tohost   = '0;
    m_exited   = 1'b0;
    m_fire_cyc = 0;
    m_code     = '0;
  endfunction

  always @(negedge CLK) begin
    if (rr_force)     a_rsp_ready = 1'b0;
    else if (rr_rand) a_rsp_ready = ($urandom_range(3) != 0);
    else              a_rsp_ready = 1'b1;
  end

  // Monitor: cycle k is the interval after the k-th rising edge since release.
  always @(posedge CLK) begin
    #1;
    if (!a_rst_n) begin
      cyc        = 0;
      prev_valid = 1'b0;
    end else begin
      cyc++;
      check("finish_arg", a_finish_arg,
            (m_exited && cyc == m_fire_cyc) ? {1'b1, m_code} : 9'h0);
      check("halted", a_halted, m_exited && cyc > m_fire_cyc);
      if (a_rsp_valid) begin
        if (prev_valid && !a_rsp_ready) begin
          check("rsp_hold", a_rsp_data, held_data);
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_extra: got response %0h expected none at t=%0t", a_rsp_data, $time);
        end else begin
          check("rsp_data", a_rsp_data, exp_q.pop_front());
        end
        held_data = a_rsp_data;
      end else begin
        check("rsp_missing", exp_q.size(), 0);
      end
      prev_valid = a_rsp_valid;
    end
  end

  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] data);
    bit done = 1'b0;
    @(negedge CLK);
    a_req_valid = 1'b1;
    a_req_wen   = wen;
    a_req_addr  = addr;
    a_req_data  = data;
    for (int i = 0; i < 40 && !done; i++) begin
      if (i > 0) @(negedge CLK);
      #4;
      if (a_req_ready) begin
        model_accept(wen, addr, data);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no acceptance expected one within 40 cycles at t=%0t", $time);
    end
    @(posedge CLK);
    #1;
    a_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic reset_a();
    @(negedge CLK);
    a_rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_rsp_valid", a_rsp_valid, 1'b0);
    check("rst_rsp_data", a_rsp_data, 32'h0);
    check("rst_finish_arg", a_finish_arg, 9'h0);
    check("rst_halted", a_halted, 1'b0);
    check("rst_req_ready", a_req_ready, 1'b1);
    repeat (3) @(negedge CLK);
    a_rst_n = 1'b1;
  endtask

  task automatic run_b(input bit with_store, input logic [8:0] exp_arg);
    @(negedge CLK);
    b_rst_n     = 1'b0;
    b_req_valid = 1'b0;
    repeat (2) @(negedge CLK);
    b_rst_n = 1'b1;
    for (int c = 1; c <= 115; c++) begin
      @(posedge CLK);
      #1;
      if (c == 101) b_req_valid = 1'b0;
      check("b_finish_arg", b_finish_arg, (c == 105) ? exp_arg : 9'h0);
      check("b_halted", b_halted, c > 105);
      if (with_store && c == 100) begin
        @(negedge CLK);
        b_req_valid = 1'b1;
        b_req_wen   = 1'b1;
        b_req_addr  = TOHOST;
        b_req_data  = 32'h0000_0043;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before t=500000");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    a_rst_n = 1'b0; a_req_valid = 1'b0; a_req_wen = 1'b0; a_req_addr = '0; a_req_data = '0;
    a_rsp_ready = 1'b1;
    b_rst_n = 1'b0; b_req_valid = 1'b0; b_req_wen = 1'b0; b_req_addr = '0; b_req_data = '0;
    b_rsp_ready = 1'b1;
    model_reset();

    // Exit code 0 accepted in cycle 10: pulse in cycle 15, then MMIO while halted.
    reset_a();
    while (cyc < 9) @(negedge CLK);
    do_req(1'b1, TOHOST, 32'h1);
    idle(12);
    do_req(1'b0, TOHOST, 32'h0);
    do_req(1'b1, TOHOST, 32'h3);
    do_req(1'b0, TOHOST, 32'h0);
    idle(4);

    // First exit wins over a second exit store during the drain.
    reset_a();
    do_req(1'b1, TOHOST, 32'h0000_000B);
    idle(1);
    do_req(1'b1, TOHOST, 32'h3);
    idle(12);
    do_req(1'b0, TOHOST, 32'h0);

    // Even value latched without an exit; other addresses read as 0.
    reset_a();
    do_req(1'b1, TOHOST, 32'h2);
    do_req(1'b0, TOHOST, 32'h0);
    do_req(1'b0, 32'h0, 32'h0);
    do_req(1'b1, 32'h0, 32'h5);
    idle(20);

    // Response back-pressure with a request waiting behind it.
    reset_a();
    do_req(1'b1, TOHOST, 32'h44);
    idle(2);
    rr_force = 1'b1;
    do_req(1'b0, TOHOST, 32'h0);
    fork
      do_req(1'b0, 32'h0, 32'h0);
      begin
        repeat (3) begin
          @(negedge CLK);
          #4;
          check("req_ready_stall", a_req_ready, 1'b0);
        end
        rr_force = 1'b0;
      end
    join
    idle(4);

    // Reset in the middle of the drain: no pulse afterwards.
    reset_a();
    do_req(1'b1, TOHOST, 32'h0000_0041);
    idle(2);
    reset_a();
    idle(15);

    // Random traffic with random response back-pressure.
    reset_a();
    rr_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] d, ad;
      int sel;
      d   = $urandom;
      if ($urandom_range(15) != 0) d[0] = 1'b0;
      sel = $urandom_range(3);
      ad  = (sel < 2) ? TOHOST : ((sel == 2) ? 32'h0 : $urandom);
      do_req($urandom_range(1) == 1, ad, d);
      if ($urandom_range(3) == 0) idle($urandom_range(3));
    end
    rr_rand = 1'b0;
    idle(10);

    // Watchdog instance: timeout code, then a store on the expiry cycle.
    run_b(1'b0, 9'h1FF);
    run_b(1'b1, 9'h121);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
